// File: rtl/pipe_stage_hs_pkg.sv
// Shared definitions for the handshaked pipeline stage register: skid-mode
// state encoding and the decode of which entry register loads each cycle.
package pipe_stage_hs_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef enum logic [1:0] {
        LOAD_NONE      = 2'd0,
        LOAD_MAIN_IN   = 2'd1,
        LOAD_SKID_IN   = 2'd2,
        LOAD_MAIN_SKID = 2'd3
    } load_sel_t;

    function automatic logic [1:0] skid_next_state(
        input logic [1:0] state,
        input logic       accept,
        input logic       out_fire
    );
        logic [1:0] nxt;
        nxt = state;
        case (state)
            ST_EMPTY: if (accept) nxt = ST_ONE;
            ST_ONE: begin
                if (accept && !out_fire)
                    nxt = ST_TWO;
                else if (out_fire && !accept)
                    nxt = ST_EMPTY;
            end
            ST_TWO:   if (out_fire) nxt = ST_ONE;
            default:  nxt = ST_EMPTY;
        endcase
        return nxt;
    endfunction

    // Simultaneous accept and drain while holding one entry refills main
    // directly, so the skid slot is only used when downstream is stalled.
    function automatic load_sel_t skid_load_sel(
        input logic [1:0] state,
        input logic       accept,
        input logic       out_fire
    );
        load_sel_t sel;
        sel = LOAD_NONE;
        case (state)
            ST_EMPTY: if (accept) sel = LOAD_MAIN_IN;
            ST_ONE: begin
                if (accept)
                    sel = out_fire ? LOAD_MAIN_IN : LOAD_SKID_IN;
            end
            ST_TWO:   if (out_fire) sel = LOAD_MAIN_SKID;
            default:  sel = LOAD_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clr)
            count_reg <= '0;
        else if (inc && (count_reg != '1))
            count_reg <= count_reg + CNT_W'(1);
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready inter-stage register with optional two-entry skid buffer,
// synchronous flush, bubble (NOP) insertion and a saturating stall counter.
module pipe_stage_hs
    import pipe_stage_hs_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 12,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_bubble,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              clr_cnt
);

    logic              accept;
    logic              out_fire;
    logic [CTRL_W-1:0] in_ctrl_eff;

    assign accept      = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign in_ctrl_eff = in_bubble ? '0 : in_ctrl;

    generate
        if (SKID == 0) begin : g_single
            logic              valid_reg;
            logic [DATA_W-1:0] data_reg;
            logic [CTRL_W-1:0] ctrl_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                    ctrl_reg  <= '0;
                end else if (flush) begin
                    valid_reg <= 1'b0;
                    ctrl_reg  <= '0;
                end else if (accept) begin
                    valid_reg <= 1'b1;
                    data_reg  <= in_data;
                    ctrl_reg  <= in_ctrl_eff;
                end else if (out_fire) begin
                    valid_reg <= 1'b0;
                end
            end

            assign in_ready  = !rst && (!valid_reg || out_ready);
            assign out_valid = valid_reg;
            assign out_data  = data_reg;
            assign out_ctrl  = ctrl_reg;
        end else begin : g_skid
            logic [1:0]        state_reg;
            logic [1:0]        state_next;
            logic              ready_reg;
            load_sel_t         load_sel;
            logic [DATA_W-1:0] main_data_reg;
            logic [CTRL_W-1:0] main_ctrl_reg;
            logic [DATA_W-1:0] skid_data_reg;
            logic [CTRL_W-1:0] skid_ctrl_reg;

            assign state_next = skid_next_state(state_reg, accept, out_fire);
            assign load_sel   = skid_load_sel(state_reg, accept, out_fire);

            // ready_reg mirrors "next state is not TWO" so in_ready never
            // depends combinationally on out_ready.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg     <= ST_EMPTY;
                    ready_reg     <= 1'b1;
                    main_data_reg <= '0;
                    main_ctrl_reg <= '0;
                    skid_data_reg <= '0;
                    skid_ctrl_reg <= '0;
                end else if (flush) begin
                    state_reg     <= ST_EMPTY;
                    ready_reg     <= 1'b1;
                    main_ctrl_reg <= '0;
                end else begin
                    state_reg <= state_next;
                    ready_reg <= (state_next != ST_TWO);
                    case (load_sel)
                        LOAD_MAIN_IN: begin
                            main_data_reg <= in_data;
                            main_ctrl_reg <= in_ctrl_eff;
                        end
                        LOAD_SKID_IN: begin
                            skid_data_reg <= in_data;
                            skid_ctrl_reg <= in_ctrl_eff;
                        end
                        LOAD_MAIN_SKID: begin
                            main_data_reg <= skid_data_reg;
                            main_ctrl_reg <= skid_ctrl_reg;
                        end
                        default: ;
                    endcase
                end
            end

            assign in_ready  = ready_reg && !rst;
            assign out_valid = (state_reg != ST_EMPTY);
            assign out_data  = main_data_reg;
            assign out_ctrl  = main_ctrl_reg;
        end
    endgenerate

    pipe_sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (out_valid && !out_ready),
        .clr  (clr_cnt),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Scoreboard bench: DUT k has SKID=k; a FIFO model predicts every output word,
// ready level and stall count. A third instance (CNT_W=4) checks saturation.
module tb_pipe_stage_hs;

    localparam int DW = 32;
    localparam int CW = 12;
    typedef logic [DW+CW-1:0] ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          iv   [2];
    logic          irdy [2];
    logic          bub  [2];
    logic          fl   [2];
    logic          ov   [2];
    logic          ordy [2];
    logic          clr  [2];
    logic [DW-1:0] idat [2];
    logic [DW-1:0] odat [2];
    logic [CW-1:0] ictl [2];
    logic [CW-1:0] octl [2];
    logic [15:0]   scnt [2];

    logic          s_iv, s_irdy, s_ov, s_or, s_clr;
    logic [DW-1:0] s_idat, s_odat;
    logic [CW-1:0] s_ictl, s_octl;
    logic [3:0]    s_cnt;

    int   n_cmp = 0;
    int   n_err = 0;
    ent_t exp_q [2][$];
    int   cnt_m [2];
    bit   post_flush [2];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            pipe_stage_hs #(
                .DATA_W(DW), .CTRL_W(CW), .SKID(gi), .CNT_W(16)
            ) u_dut (
                .clk(clk), .rst(rst),
                .in_valid(iv[gi]), .in_ready(irdy[gi]),
                .in_data(idat[gi]), .in_ctrl(ictl[gi]),
                .in_bubble(bub[gi]), .flush(fl[gi]),
                .out_valid(ov[gi]), .out_ready(ordy[gi]),
                .out_data(odat[gi]), .out_ctrl(octl[gi]),
                .stall_cnt(scnt[gi]), .clr_cnt(clr[gi])
            );
        end
    endgenerate

    pipe_stage_hs #(
        .DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)
    ) u_sat (
        .clk(clk), .rst(rst),
        .in_valid(s_iv), .in_ready(s_irdy),
        .in_data(s_idat), .in_ctrl(s_ictl),
        .in_bubble(1'b0), .flush(1'b0),
        .out_valid(s_ov), .out_ready(s_or),
        .out_data(s_odat), .out_ctrl(s_octl),
        .stall_cnt(s_cnt), .clr_cnt(s_clr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: reference is an ordered list of accepted entries per DUT.
    int   sz;
    logic er;
    ent_t e;
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                chk($sformatf("rst_in_ready%0d", k), 64'(irdy[k]), 64'(0));
                exp_q[k].delete();
                cnt_m[k]      = 0;
                post_flush[k] = 1'b0;
            end else begin
                sz = exp_q[k].size();
                er = (k == 1) ? (sz < 2) : (sz == 0 || ordy[k]);
                chk($sformatf("in_ready%0d", k), 64'(irdy[k]), 64'(er));
                chk($sformatf("out_valid%0d", k), 64'(ov[k]), 64'(sz != 0));
                if (sz != 0) begin
                    e = exp_q[k][0];
                    chk($sformatf("out_data%0d", k), 64'(odat[k]), 64'(e[DW+CW-1:CW]));
                    chk($sformatf("out_ctrl%0d", k), 64'(octl[k]), 64'(e[CW-1:0]));
                end
                if (post_flush[k]) begin
                    chk($sformatf("flush_ctrl%0d", k), 64'(octl[k]), 64'(0));
                    post_flush[k] = 1'b0;
                end
                chk($sformatf("stall_cnt%0d", k), 64'(scnt[k]), 64'(cnt_m[k]));
                if (clr[k])
                    cnt_m[k] = 0;
                else if (sz != 0 && !ordy[k] && cnt_m[k] < 65535)
                    cnt_m[k] = cnt_m[k] + 1;
                if (sz != 0 && ordy[k])
                    void'(exp_q[k].pop_front());
                if (fl[k]) begin
                    exp_q[k].delete();
                    post_flush[k] = 1'b1;
                end else if (iv[k] && er) begin
                    exp_q[k].push_back({idat[k], bub[k] ? CW'(0) : ictl[k]});
                end
            end
        end
    end

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; bub[k] = 1'b0; fl[k] = 1'b0; clr[k] = 1'b0; ordy[k] = 1'b1;
        end
    endtask

    task automatic random_burst(input int n);
        for (int c = 0; c < n; c++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                iv[k]   = ($urandom_range(0, 9) < 7);
                idat[k] = $urandom;
                ictl[k] = CW'($urandom);
                bub[k]  = ($urandom_range(0, 9) == 0);
                fl[k]   = ($urandom_range(0, 49) == 0);
                ordy[k] = ($urandom_range(0, 9) < 6);
                clr[k]  = ($urandom_range(0, 99) == 0);
            end
        end
    endtask

    initial begin
        // Reset with traffic presented on every input
        rst = 1'b1;
        idle_all();
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b1; idat[k] = 32'hDEAD; ictl[k] = 12'hABC; ordy[k] = 1'b0;
        end
        s_iv = 1'b1; s_idat = 32'hDEAD; s_ictl = 12'hABC; s_or = 1'b0; s_clr = 1'b0;
        repeat (2) step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_out_valid%0d", k), 64'(ov[k]), 64'(0));
            chk($sformatf("rst_out_ctrl%0d", k), 64'(octl[k]), 64'(0));
            chk($sformatf("rst_out_data%0d", k), 64'(odat[k]), 64'(0));
            chk($sformatf("rst_stall%0d", k), 64'(scnt[k]), 64'(0));
        end
        step();
        rst = 1'b0;
        idle_all();
        s_iv = 1'b0;

        // In-order stream, one-cycle latency, both configurations
        for (int i = 0; i <= 8; i++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                iv[k]   = (i < 8);
                idat[k] = 32'(16 + i);
                ictl[k] = CW'($urandom);
            end
            if (i >= 1) begin
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("stream_valid%0d_%0d", k, i), 64'(ov[k]), 64'(1));
                    chk($sformatf("stream_data%0d_%0d", k, i), 64'(odat[k]), 64'(15 + i));
                end
            end
        end
        idle_all();
        step(); step();

        // Skid fills to two entries under stall, then drains A then B
        step(); ordy[1] = 1'b0; clr[1] = 1'b1; iv[1] = 1'b1;
        idat[1] = 32'hA0A0_0001; ictl[1] = 12'h123;
        step(); clr[1] = 1'b0; idat[1] = 32'hB0B0_0002; ictl[1] = 12'h456;
        step(); iv[1] = 1'b0;
        @(negedge clk);
        chk("two_in_ready", 64'(irdy[1]), 64'(0));
        chk("two_hold_a", 64'(odat[1]), 64'(32'hA0A0_0001));
        step(); step(); step(); ordy[1] = 1'b1;
        @(negedge clk);
        chk("drain_a", 64'(odat[1]), 64'(32'hA0A0_0001));
        step();
        @(negedge clk);
        chk("drain_b", 64'(odat[1]), 64'(32'hB0B0_0002));
        chk("drain_b_valid", 64'(ov[1]), 64'(1));
        step();
        @(negedge clk);
        chk("stall_count_4", 64'(scnt[1]), 64'(4));
        chk("drained_valid", 64'(ov[1]), 64'(0));

        // Bubble keeps data, zeroes ctrl
        step(); iv[1] = 1'b1; bub[1] = 1'b1; ictl[1] = 12'hFFF; idat[1] = 32'h55; ordy[1] = 1'b0;
        step(); iv[1] = 1'b0; bub[1] = 1'b0;
        @(negedge clk);
        chk("bubble_valid", 64'(ov[1]), 64'(1));
        chk("bubble_ctrl", 64'(octl[1]), 64'(0));
        chk("bubble_data", 64'(odat[1]), 64'(32'h55));
        step(); ordy[1] = 1'b1;
        step(); step();

        // Flush while holding two entries with a third presented
        step(); iv[1] = 1'b1; idat[1] = 32'hC001; ictl[1] = 12'h0F1; ordy[1] = 1'b0;
        step(); idat[1] = 32'hC002; ictl[1] = 12'h0F2;
        step(); idat[1] = 32'hC003; ictl[1] = 12'h0F3; fl[1] = 1'b1;
        @(negedge clk);
        chk("pre_flush_ready", 64'(irdy[1]), 64'(0));
        step(); fl[1] = 1'b0; iv[1] = 1'b0; ordy[1] = 1'b1;
        @(negedge clk);
        chk("flush_valid", 64'(ov[1]), 64'(0));
        chk("flush_ready", 64'(irdy[1]), 64'(1));
        chk("flush_ctrl", 64'(octl[1]), 64'(0));
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            chk($sformatf("post_flush_valid_%0d", i), 64'(ov[1]), 64'(0));
        end

        // Saturation at 15 for a 4-bit counter, clear while still stalled
        step(); s_iv = 1'b1; s_idat = 32'h77; s_or = 1'b0;
        step(); s_iv = 1'b0;
        repeat (20) step();
        @(negedge clk);
        chk("sat_count", 64'(s_cnt), 64'(15));
        chk("sat_hold_data", 64'(s_odat), 64'(32'h77));
        step(); s_clr = 1'b1;
        step(); s_clr = 1'b0;
        @(negedge clk);
        chk("sat_clr", 64'(s_cnt), 64'(0));
        step();
        @(negedge clk);
        chk("sat_after_clr", 64'(s_cnt), 64'(1));
        s_or = 1'b1;

        // Randomised traffic, a mid-run reset, then more traffic and drain
        random_burst(1500);
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        random_burst(800);
        step(); idle_all();
        repeat (5) step();
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            chk($sformatf("final_valid%0d", k), 64'(ov[k]), 64'(0));

        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
